timer_irq_src: RTL and testbench

//  Memory-mapped machine timer: the interrupt source that drives the core's int_flag_i.

---
 rtl/timer_irq_src.sv | 76 +++++++
 tb/tb_timer_irq_src.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_src.sv
// timer_irq_src: prescaled compare timer with a sticky pending flag cleared by W1C, in one-shot or auto-reload mode
module timer_irq_src #(
  parameter int INT_W   = 8,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic [INT_W-1:0]  int_flag_o
);
  logic en, ie, pend, auto_rl;
  logic en_n, ie_n, pend_n, auto_n;
  logic [31:0] count, cmp, count_n, cmp_n, rd_val;
  logic [PRESC_W-1:0] presc, cnt, presc_n, cnt_n;
  logic [1:0] sel;
  logic wr, rd, wr_ctrl, wr_count, wr_cmp, wr_presc, tick, hit;
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:4], addr_i[1:0]};
  assign sel = addr_i[3:2];
  assign wr = req_i & we_i;
  assign rd = req_i & ~we_i;
  assign wr_ctrl = wr & (sel == 2'd0);
  assign wr_count = wr & (sel == 2'd1);
  assign wr_cmp = wr & (sel == 2'd2);
  assign wr_presc = wr & (sel == 2'd3);
  assign tick = en & (cnt == presc);
  assign hit = tick & (count == cmp);
  always_comb begin
    en_n = wr_ctrl ? wdata_i[0] : (hit & ~auto_rl) ? 1'b0 : en;
    ie_n = wr_ctrl ? wdata_i[1] : ie;
    auto_n = wr_ctrl ? wdata_i[3] : auto_rl;
    // a hardware set on this edge outranks a software clear
    pend_n = hit | (pend & ~(wr_ctrl & wdata_i[2]));
    count_n = wr_count ? wdata_i : hit ? 32'd0 : tick ? count + 32'd1 : count;
    cmp_n = wr_cmp ? wdata_i : cmp;
    presc_n = wr_presc ? wdata_i[PRESC_W-1:0] : presc;
    // the prescaler only runs while enabled both before and after this edge
    cnt_n = (~en | ~en_n | wr_presc | tick) ? '0 : cnt + 1'b1;
    rd_val = sel == 2'd0 ? {28'd0, auto_rl, pend, ie, en} :
             sel == 2'd1 ? count :
             sel == 2'd2 ? cmp : {{(32-PRESC_W){1'b0}}, presc};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en <= 1'b0;
      ie <= 1'b0;
      pend <= 1'b0;
      auto_rl <= 1'b0;
      count <= '0;
      cmp <= 32'hFFFF_FFFF;
      presc <= '0;
      cnt <= '0;
      rdata_o <= '0;
      rvalid_o <= 1'b0;
      int_flag_o <= '0;
    end else begin
      en <= en_n;
      ie <= ie_n;
      pend <= pend_n;
      auto_rl <= auto_n;
      count <= count_n;
      cmp <= cmp_n;
      presc <= presc_n;
      cnt <= cnt_n;
      rdata_o <= rd ? rd_val : rdata_o;
      rvalid_o <= rd;
      int_flag_o <= {{(INT_W-1){1'b0}}, pend & ie};
    end
  end
endmodule

// File: tb/tb_timer_irq_src.sv
// tb_timer_irq_src: directed and randomized checks of timer_irq_src against a cycle-level reference model
module tb_timer_irq_src;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic req_i = 1'b0;
  logic we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic rvalid_o;
  logic [7:0] int_flag_o;
  int checks = 0;
  int errors = 0;
  bit m_en, m_ie, m_pend, m_auto, m_rvalid;
  bit [31:0] m_count, m_cmp, m_rdata;
  bit [15:0] m_presc, m_cnt;
  bit [7:0] m_flag;

  timer_irq_src dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .int_flag_o(int_flag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] reg_val(input bit [1:0] a);
    case (a)
      2'd0: return {28'd0, m_auto, m_pend, m_ie, m_en};
      2'd1: return m_count;
      2'd2: return m_cmp;
      default: return {16'd0, m_presc};
    endcase
  endfunction

  // Apply one bus cycle, advance the model by the register-map rules, then compare the outputs.
  task automatic step(input bit r, input bit rq, input bit w, input bit [1:0] a, input bit [31:0] d);
    bit tick, expire;
    rst_i = r; req_i = rq; we_i = w; addr_i = {28'd0, a, 2'b00}; wdata_i = d;
    if (r) begin
      {m_en, m_ie, m_pend, m_auto, m_rvalid} = '0;
      m_count = 0; m_cmp = 32'hFFFF_FFFF; m_presc = 0; m_cnt = 0; m_rdata = 0; m_flag = 0;
    end else begin
      tick = m_en && (m_cnt == m_presc);
      expire = tick && (m_count == m_cmp);
      m_rvalid = rq && !w;
      if (m_rvalid) m_rdata = reg_val(a);
      m_flag = {7'd0, m_pend & m_ie};
      if (tick) m_cnt = 0; else if (m_en) m_cnt = m_cnt + 1;
      if (expire) begin
        m_count = 0; m_pend = 1;
        if (!m_auto) m_en = 0;
      end else if (tick) m_count = m_count + 1;
      if (rq && w) begin
        case (a)
          2'd0: begin
            m_en = d[0]; m_ie = d[1]; m_auto = d[3];
            if (d[2] && !expire) m_pend = 0;
          end
          2'd1: m_count = d;
          2'd2: m_cmp = d;
          default: begin m_presc = d[15:0]; m_cnt = 0; end
        endcase
      end
      if (!m_en) m_cnt = 0;
    end
    @(posedge clk_i);
    #1;
    chk("flag", {24'd0, int_flag_o}, {24'd0, m_flag});
    chk("rvalid", {31'd0, rvalid_o}, {31'd0, m_rvalid});
    chk("rdata", rdata_o, m_rdata);
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d);
    step(0, 1, 1, a, d);
  endtask

  task automatic rd(input bit [1:0] a);
    step(0, 1, 0, a, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  // Cycles until int_flag_o[0] rises; a timeout returns 99 and fails the caller's check.
  task automatic wait_flag(output int n);
    bit seen;
    seen = 0;
    n = 99;
    for (int i = 1; i <= 40 && !seen; i++) begin
      idle();
      if (int_flag_o[0]) begin n = i; seen = 1; end
    end
  endtask

  initial begin
    int n;
    bit [1:0] a;
    bit [31:0] d;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_flag", {24'd0, int_flag_o}, 32'd0);
    rd(2'd2);
    chk("reset_cmp", rdata_o, 32'hFFFF_FFFF);
    // auto-reload, period 5
    wr(2'd3, 0); wr(2'd2, 4); wr(2'd0, 32'hB);
    wait_flag(n);
    chk("auto_latency", n, 6);
    repeat (12) idle();
    rd(2'd0);
    chk("auto_ctrl", rdata_o, 32'hF);
    // one-shot, PRESC=3 CMP=1
    wr(2'd0, 0); wr(2'd0, 4); wr(2'd1, 0);
    wr(2'd3, 3); wr(2'd2, 1); wr(2'd0, 32'h3);
    wait_flag(n);
    chk("oneshot_latency", n, 9);
    rd(2'd0);
    chk("oneshot_ctrl", rdata_o, 32'h6);
    rd(2'd1);
    chk("oneshot_count", rdata_o, 0);
    // IE gating and W1C
    wr(2'd0, 0); idle();
    chk("ie_off_flag", {24'd0, int_flag_o}, 0);
    wr(2'd0, 2); idle();
    chk("ie_on_flag", {24'd0, int_flag_o}, 32'h1);
    wr(2'd0, 7); idle();
    chk("w1c_flag", {24'd0, int_flag_o}, 0);
    rd(2'd0);
    chk("w1c_ctrl", rdata_o, 32'h3);
    // W1C and EN write landing on the expiry edge
    wr(2'd0, 0); wr(2'd0, 4); wr(2'd1, 0); wr(2'd3, 0); wr(2'd2, 2);
    wr(2'd0, 1); idle(); idle(); wr(2'd0, 5);
    rd(2'd0);
    chk("w1c_race_ctrl", rdata_o, 32'h5);
    // COUNT past CMP wraps through 2^32-1
    wr(2'd0, 0); wr(2'd0, 4); wr(2'd3, 0); wr(2'd2, 4); wr(2'd1, 32'hFFFF_FFFE); wr(2'd0, 3);
    wait_flag(n);
    chk("wrap_latency", n, 8);
    rd(2'd1);
    chk("wrap_count", rdata_o, 0);
    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      if (n < 2) step(1, 0, 0, 0, 0);
      else if (n < 50) idle();
      else if (n < 65) rd(a);
      else begin
        case (a)
          2'd0: d = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hF);
          2'd1: d = $urandom_range(0, 1) ? 32'($urandom_range(0, 6)) : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          2'd2: d = 32'($urandom_range(0, 6));
          default: d = 32'($urandom_range(0, 3));
        endcase
        wr(a, d);
      end
    end
    // reset while pending
    wr(2'd0, 0); wr(2'd3, 0); wr(2'd1, 0); wr(2'd2, 0); wr(2'd0, 3); idle(); idle();
    chk("prerst_flag", {24'd0, int_flag_o}, 32'h1);
    step(1, 0, 0, 0, 0);
    chk("rst_flag", {24'd0, int_flag_o}, 0);
    rd(2'd2);
    chk("rst_cmp", rdata_o, 32'hFFFF_FFFF);
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'h1);
    rd(2'd0);
    chk("rst_ctrl", rdata_o, 0);
    rd(2'd1);
    chk("rst_count", rdata_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
